control_unit: RTL and testbench

- Timing and control stage of the basic computer. It sits directly downstream of the sequence counter and consumes its one-hot timing vector T.
- Holds the instruction-cycle state: S (run), R (interrupt cycle), IEN, I, and the decoded opcode D.
- Generates the bus select, memory strobes and register micro-operation strobes for the datapath.
- Closes the loop back to the counter by driving its S, INR and CLR inputs.

---
 rtl/basic_computer_pkg.sv | 33 +++
 rtl/control_unit_if.sv | 27 ++
 rtl/cu_state_regs.sv | 65 ++++++
 rtl/control_unit.sv | 99 +++++++++
 tb/tb_control_unit.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/basic_computer_pkg.sv
// Shared encodings for the basic computer: bus sources, ALU/E ops, strobe bit
// indices, opcodes and register-reference / I/O instruction bit positions.
package basic_computer_pkg;

  typedef enum logic [2:0] {
    BUS_NONE = 3'd0, BUS_AR = 3'd1, BUS_PC = 3'd2, BUS_DR = 3'd3,
    BUS_AC   = 3'd4, BUS_IR = 3'd5, BUS_TR = 3'd6, BUS_MEM = 3'd7
  } bus_sel_e;

  typedef enum logic [2:0] {
    ALU_NONE = 3'd0, ALU_AND = 3'd1, ALU_ADD = 3'd2, ALU_DR  = 3'd3,
    ALU_INP  = 3'd4, ALU_CMA = 3'd5, ALU_CIR = 3'd6, ALU_CIL = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {E_HOLD = 2'd0, E_CLR = 2'd1, E_CMP = 2'd2} e_op_e;

  localparam int LD_AR = 0, LD_PC = 1, LD_DR = 2, LD_AC = 3, LD_IR = 4, LD_TR = 5;
  localparam int INR_AR = 0, INR_PC = 1, INR_DR = 2, INR_AC = 3, INR_TR = 4;
  localparam int CLR_AR = 0, CLR_PC = 1, CLR_AC = 2;

  localparam int OP_AND = 0, OP_ADD = 1, OP_LDA = 2, OP_STA = 3;
  localparam int OP_BUN = 4, OP_BSA = 5, OP_ISZ = 6, OP_D7 = 7;

  localparam int RR_CLA = 11, RR_CLE = 10, RR_CMA = 9, RR_CME = 8, RR_CIR = 7, RR_CIL = 6;
  localparam int RR_INC = 5, RR_SPA = 4, RR_SNA = 3, RR_SZA = 2, RR_SZE = 1, RR_HLT = 0;

  localparam int IO_INP = 11, IO_OUT = 10, IO_SKI = 9, IO_SKO = 8, IO_ION = 7, IO_IOF = 6;

  function automatic logic [7:0] onehot8(input logic [2:0] op);
    onehot8 = 8'b1 << op;
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control-unit <-> datapath/sequence-counter bundle. master = control unit side.
interface control_unit_if #(parameter int T_W = 16);
  logic           start;
  logic [T_W-1:0] t;
  logic [15:0]    ir;
  logic           ac_sign, ac_zero, e_flag, dr_zero, fgi, fgo;
  logic           sc_s, sc_inr, sc_clr;
  logic [2:0]     bus_sel;
  logic           mem_rd, mem_wr;
  logic [5:0]     ld;
  logic [4:0]     inr;
  logic [2:0]     clr;
  logic [2:0]     alu_op;
  logic [1:0]     e_op;
  logic           out_ld, fgi_clr, fgo_clr;

  modport master (
    input  start, t, ir, ac_sign, ac_zero, e_flag, dr_zero, fgi, fgo,
    output sc_s, sc_inr, sc_clr, bus_sel, mem_rd, mem_wr, ld, inr, clr,
           alu_op, e_op, out_ld, fgi_clr, fgo_clr
  );
  modport slave (
    output start, t, ir, ac_sign, ac_zero, e_flag, dr_zero, fgi, fgo,
    input  sc_s, sc_inr, sc_clr, bus_sel, mem_rd, mem_wr, ld, inr, clr,
           alu_op, e_op, out_ld, fgi_clr, fgo_clr
  );
endinterface

// File: rtl/cu_state_regs.sv
// Instruction-cycle state: S, R, IEN, I and decoded opcode D.
// R/IEN exist only when CU_INTERRUPT_EN is defined; otherwise they read 0.
module cu_state_regs
  import basic_computer_pkg::*;
#(
  parameter int T_W    = 16,
  parameter int ADDR_W = 12
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           t_ok,
  input  logic [T_W-1:0] t,
  input  logic [15:0]    ir,
  input  logic           irq,
  output logic           s,
  output logic           r,
  output logic           i_bit,
  output logic [7:0]     d
);
  logic exec_t3, halt, unused_bits;

  assign exec_t3     = s & t_ok & t[3] & d[OP_D7];
  assign halt        = exec_t3 & ~i_bit & ir[RR_HLT];
  assign unused_bits = ^{ir[ADDR_W-1:1], t[T_W-1:4]};

  always_ff @(posedge clk) begin
    if (rst) begin
      s     <= 1'b0;
      i_bit <= 1'b0;
      d     <= '0;
    end else begin
      if (!s)        s <= start;
      else if (halt) s <= 1'b0;
      if (s & t_ok & t[2] & ~r) begin
        d     <= onehot8(ir[ADDR_W+2:ADDR_W]);
        i_bit <= ir[ADDR_W+3];
      end
    end
  end

`ifdef CU_INTERRUPT_EN
  logic ien;

  always_ff @(posedge clk) begin
    if (rst) begin
      r   <= 1'b0;
      ien <= 1'b0;
    end else if (s & r & t_ok & t[2]) begin
      r   <= 1'b0;
      ien <= 1'b0;
    end else begin
      // Entry uses the current IEN, so an ION only arms the next cycle.
      if (s & ~t[0] & ~t[1] & ~t[2] & ien & irq & ~halt) r <= 1'b1;
      if (exec_t3 & i_bit & ir[IO_ION])      ien <= 1'b1;
      else if (exec_t3 & i_bit & ir[IO_IOF]) ien <= 1'b0;
    end
  end
`else
  logic unused_irq;
  assign r          = 1'b0;
  assign unused_irq = ^{irq, t[1:0]};
`endif

endmodule

// File: rtl/control_unit.sv
// Timing/control stage of the basic computer: strobe decode from T, D, I, R.
// Interrupt support is compiled in with CU_INTERRUPT_EN.
module control_unit
  import basic_computer_pkg::*;
#(
  parameter int T_W    = 16,
  parameter int ADDR_W = 12
) (
  input  logic           clk,
  input  logic           rst,
  control_unit_if.master cu
);
  logic           s, r, i_bit, t_ok;
  logic [7:0]     d;
  logic [T_W-1:0] t;
  logic [15:0]    ir;

  assign t    = cu.t;
  assign ir   = cu.ir;
  assign t_ok = (t != '0) && (t[T_W-1:7] == '0);

  cu_state_regs #(.T_W(T_W), .ADDR_W(ADDR_W)) u_regs (
    .clk(clk), .rst(rst), .start(cu.start), .t_ok(t_ok), .t(t), .ir(ir),
    .irq(cu.fgi | cu.fgo), .s(s), .r(r), .i_bit(i_bit), .d(d)
  );

  assign cu.mem_rd = (cu.bus_sel == BUS_MEM);

  always_comb begin
    cu.sc_s = 1'b0; cu.sc_clr = 1'b0; cu.bus_sel = BUS_NONE; cu.mem_wr = 1'b0;
    cu.ld = '0; cu.inr = '0; cu.clr = '0; cu.alu_op = ALU_NONE; cu.e_op = E_HOLD;
    cu.out_ld = 1'b0; cu.fgi_clr = 1'b0; cu.fgo_clr = 1'b0;
    if (rst) begin
      cu.sc_s = 1'b1; cu.sc_clr = 1'b1;
    end else if (s) begin
      cu.sc_s = 1'b1;
      if (!t_ok) begin
        cu.sc_clr = 1'b1;
      end else if (r && (t[0] || t[1] || t[2])) begin
        if (t[0]) begin cu.clr[CLR_AR] = 1'b1; cu.bus_sel = BUS_PC; cu.ld[LD_TR] = 1'b1; end
        if (t[1]) begin cu.bus_sel = BUS_TR; cu.mem_wr = 1'b1; cu.clr[CLR_PC] = 1'b1; end
        if (t[2]) begin cu.inr[INR_PC] = 1'b1; cu.sc_clr = 1'b1; end
      end else if (t[0]) begin
        cu.bus_sel = BUS_PC; cu.ld[LD_AR] = 1'b1;
      end else if (t[1]) begin
        cu.bus_sel = BUS_MEM; cu.ld[LD_IR] = 1'b1; cu.inr[INR_PC] = 1'b1;
      end else if (t[2]) begin
        cu.bus_sel = BUS_IR; cu.ld[LD_AR] = 1'b1;
      end else if (t[3]) begin
        if (d[OP_D7]) begin
          cu.sc_clr = 1'b1;
          if (i_bit) begin
            if (ir[IO_INP]) begin cu.ld[LD_AC] = 1'b1; cu.alu_op = ALU_INP; cu.fgi_clr = 1'b1; end
            if (ir[IO_OUT]) begin cu.bus_sel = BUS_AC; cu.out_ld = 1'b1; cu.fgo_clr = 1'b1; end
            if ((ir[IO_SKI] & cu.fgi) | (ir[IO_SKO] & cu.fgo)) cu.inr[INR_PC] = 1'b1;
          end else begin
            if (ir[RR_CLA]) cu.clr[CLR_AC] = 1'b1;
            if (ir[RR_CLE]) cu.e_op = E_CLR;
            if (ir[RR_CMA]) begin cu.ld[LD_AC] = 1'b1; cu.alu_op = ALU_CMA; end
            if (ir[RR_CME]) cu.e_op = E_CMP;
            if (ir[RR_CIR]) begin cu.ld[LD_AC] = 1'b1; cu.alu_op = ALU_CIR; end
            if (ir[RR_CIL]) begin cu.ld[LD_AC] = 1'b1; cu.alu_op = ALU_CIL; end
            if (ir[RR_INC]) cu.inr[INR_AC] = 1'b1;
            if ((ir[RR_SPA] & ~cu.ac_sign) | (ir[RR_SNA] & cu.ac_sign) |
                (ir[RR_SZA] & cu.ac_zero)  | (ir[RR_SZE] & ~cu.e_flag))
              cu.inr[INR_PC] = 1'b1;
          end
        end else if (i_bit) begin
          cu.bus_sel = BUS_MEM; cu.ld[LD_AR] = 1'b1;
        end
      end else begin
        // T4..T6: memory-reference execute phases
        if (d[OP_AND] | d[OP_ADD] | d[OP_LDA]) begin
          if (t[4]) begin cu.bus_sel = BUS_MEM; cu.ld[LD_DR] = 1'b1; end
          if (t[5]) begin
            cu.ld[LD_AC] = 1'b1; cu.sc_clr = 1'b1;
            cu.alu_op = d[OP_AND] ? ALU_AND : (d[OP_ADD] ? ALU_ADD : ALU_DR);
          end
        end
        if (d[OP_STA] & t[4]) begin cu.bus_sel = BUS_AC; cu.mem_wr = 1'b1; cu.sc_clr = 1'b1; end
        if (d[OP_BUN] & t[4]) begin cu.bus_sel = BUS_AR; cu.ld[LD_PC] = 1'b1; cu.sc_clr = 1'b1; end
        if (d[OP_BSA]) begin
          if (t[4]) begin cu.bus_sel = BUS_PC; cu.mem_wr = 1'b1; cu.inr[INR_AR] = 1'b1; end
          if (t[5]) begin cu.bus_sel = BUS_AR; cu.ld[LD_PC] = 1'b1; cu.sc_clr = 1'b1; end
        end
        if (d[OP_ISZ]) begin
          if (t[4]) begin cu.bus_sel = BUS_MEM; cu.ld[LD_DR] = 1'b1; end
          if (t[5]) cu.inr[INR_DR] = 1'b1;
          if (t[6]) begin
            cu.bus_sel = BUS_DR; cu.mem_wr = 1'b1; cu.sc_clr = 1'b1;
            cu.inr[INR_PC] = cu.dr_zero;
          end
        end
      end
    end
    cu.sc_inr = s && !rst && !cu.sc_clr;
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed + random bench for control_unit against an instruction-level model
// that also plays the sequence counter.
module tb_control_unit;
`ifdef CU_INTERRUPT_EN
  localparam bit INTR = 1'b1;
`else
  localparam bit INTR = 1'b0;
`endif

  typedef struct packed {
    logic       sc_s, sc_inr, sc_clr;
    logic [2:0] bus;
    logic       rd, wr;
    logic [5:0] ld;   // {TR,IR,AC,DR,PC,AR}
    logic [4:0] inr;  // {TR,AC,DR,PC,AR}
    logic [2:0] clr;  // {AC,PC,AR}
    logic [2:0] alu;
    logic [1:0] eop;
    logic       out_ld, fgi_clr, fgo_clr;
  } outs_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  control_unit_if #(.T_W(16)) bus_if ();
  control_unit #(.T_W(16), .ADDR_W(12)) dut (.clk(clk), .rst(rst), .cu(bus_if.master));

  // stimulus
  logic start, ac_sign, ac_zero, e_flag, dr_zero, fgi, fgo, force_t;
  logic [15:0] ir, forced;
  // reference model state
  bit m_s, m_r, m_ien;
  logic [15:0] cur_ir;
  int sc, cyc;
  int n_checks, n_bad;

  function automatic int step_of(input logic [15:0] tv);
    step_of = -1;
    for (int i = 0; i < 16; i++) if (tv == (16'h1 << i)) step_of = i;
  endfunction

  function automatic outs_t model(input logic [15:0] tv);
    outs_t o;
    int k;
    int op;
    bit ind;
    o = '0;
    k = step_of(tv);
    op = int'(cur_ir[14:12]);
    ind = cur_ir[15];
    if (rst) begin o.sc_s = 1; o.sc_clr = 1; return o; end
    if (!m_s) return o;
    o.sc_s = 1;
    if (k < 0 || k > 6) o.sc_clr = 1;
    else if (m_r && k <= 2) begin
      case (k)
        0: begin o.clr[0] = 1; o.bus = 2; o.ld[5] = 1; end
        1: begin o.bus = 6; o.wr = 1; o.clr[1] = 1; end
        default: begin o.inr[1] = 1; o.sc_clr = 1; end
      endcase
    end else if (k == 0) begin o.bus = 2; o.ld[0] = 1; end
    else if (k == 1) begin o.bus = 7; o.ld[4] = 1; o.inr[1] = 1; end
    else if (k == 2) begin o.bus = 5; o.ld[0] = 1; end
    else if (k == 3 && op == 7 && !ind) begin
      o.sc_clr = 1;
      if (ir[11]) o.clr[2] = 1;
      if (ir[10]) o.eop = 1;
      if (ir[9]) begin o.ld[3] = 1; o.alu = 5; end
      if (ir[8]) o.eop = 2;
      if (ir[7]) begin o.ld[3] = 1; o.alu = 6; end
      if (ir[6]) begin o.ld[3] = 1; o.alu = 7; end
      if (ir[5]) o.inr[3] = 1;
      if ((ir[4] && !ac_sign) || (ir[3] && ac_sign) || (ir[2] && ac_zero) || (ir[1] && !e_flag))
        o.inr[1] = 1;
    end else if (k == 3 && op == 7) begin
      o.sc_clr = 1;
      if (ir[11]) begin o.ld[3] = 1; o.alu = 4; o.fgi_clr = 1; end
      if (ir[10]) begin o.bus = 4; o.out_ld = 1; o.fgo_clr = 1; end
      if ((ir[9] && fgi) || (ir[8] && fgo)) o.inr[1] = 1;
    end else if (k == 3) begin
      if (ind) begin o.bus = 7; o.ld[0] = 1; end
    end else if (op <= 2) begin
      if (k == 4) begin o.bus = 7; o.ld[2] = 1; end
      if (k == 5) begin o.ld[3] = 1; o.alu = 3'(op + 1); o.sc_clr = 1; end
    end else if (op == 3 && k == 4) begin o.bus = 4; o.wr = 1; o.sc_clr = 1; end
    else if (op == 4 && k == 4) begin o.bus = 1; o.ld[1] = 1; o.sc_clr = 1; end
    else if (op == 5) begin
      if (k == 4) begin o.bus = 2; o.wr = 1; o.inr[0] = 1; end
      if (k == 5) begin o.bus = 1; o.ld[1] = 1; o.sc_clr = 1; end
    end else if (op == 6) begin
      if (k == 4) begin o.bus = 7; o.ld[2] = 1; end
      if (k == 5) o.inr[2] = 1;
      if (k == 6) begin o.bus = 3; o.wr = 1; o.inr[1] = dr_zero; o.sc_clr = 1; end
    end
    o.sc_inr = !o.sc_clr;
    o.rd = (o.bus == 7);
    return o;
  endfunction

  task automatic model_edge(input logic [15:0] tv, input outs_t o);
    int k;
    bit d7, ind, halt, ion, iof;
    k = step_of(tv);
    d7 = (cur_ir[14:12] == 3'd7);
    ind = cur_ir[15];
    if (rst) begin
      m_s = 0; m_r = 0; m_ien = 0; cur_ir = '0; sc = 0;
      return;
    end
    halt = m_s && k == 3 && d7 && !ind && ir[0];
    ion = INTR && m_s && k == 3 && d7 && ind && ir[7];
    iof = INTR && m_s && k == 3 && d7 && ind && ir[6];
    if (m_s && k == 2 && !m_r) cur_ir = ir;
    if (INTR && m_s && m_r && k == 2) begin
      m_r = 0; m_ien = 0;
    end else begin
      if (INTR && m_s && !(tv[0] || tv[1] || tv[2]) && m_ien && (fgi || fgo) && !halt) m_r = 1;
      if (ion) m_ien = 1;
      else if (iof) m_ien = 0;
    end
    m_s = m_s ? !halt : start;
    if (o.sc_s) sc = o.sc_clr ? 0 : (o.sc_inr ? sc + 1 : sc);
  endtask

  task automatic tick(input string tag);
    outs_t e, a;
    logic [15:0] tv;
    if (force_t) tv = forced;
    else begin tv = '0; tv[sc] = 1'b1; end
    bus_if.t = tv; bus_if.ir = ir; bus_if.start = start;
    bus_if.ac_sign = ac_sign; bus_if.ac_zero = ac_zero; bus_if.e_flag = e_flag;
    bus_if.dr_zero = dr_zero; bus_if.fgi = fgi; bus_if.fgo = fgo;
    #1;
    e = model(tv);
    a = {bus_if.sc_s, bus_if.sc_inr, bus_if.sc_clr, bus_if.bus_sel, bus_if.mem_rd,
         bus_if.mem_wr, bus_if.ld, bus_if.inr, bus_if.clr, bus_if.alu_op, bus_if.e_op,
         bus_if.out_ld, bus_if.fgi_clr, bus_if.fgo_clr};
    n_checks++;
    assert (a === e) else begin
      n_bad++;
      $error("FAIL %s cyc=%0d t=%h ir=%h observed=%h expected=%h", tag, cyc, tv, ir, a, e);
    end
    @(posedge clk);
    model_edge(tv, e);
    cyc++;
    @(negedge clk);
  endtask

  task automatic run_instr(input logic [15:0] v, input string tag);
    int n;
    n = 0;
    ir = v;
    do begin tick(tag); n++; end while (sc != 0 && n < 20);
    n_checks++;
    assert (sc == 0) else begin
      n_bad++;
      $error("FAIL %s-bound observed sc=%0d expected sc=0 within 20 cycles", tag, sc);
    end
  endtask

  function automatic logic [15:0] rand_instr();
    logic [15:0] v;
    case ($urandom_range(0, 3))
      0, 1: begin
        v = 16'($urandom);
        if (v[14:12] == 3'd7) v[14:12] = 3'($urandom_range(0, 6));
      end
      2: v = 16'h7000 | (16'h1 << $urandom_range(0, 11));
      default: v = 16'hF000 | (16'h1 << $urandom_range(6, 11));
    endcase
    return v;
  endfunction

  initial begin
    n_checks = 0; n_bad = 0; cyc = 0; sc = 0;
    m_s = 0; m_r = 0; m_ien = 0; cur_ir = '0;
    rst = 1; start = 0; force_t = 0; forced = '0; ir = '0;
    ac_sign = 0; ac_zero = 0; e_flag = 0; dr_zero = 0; fgi = 0; fgo = 0;
    @(negedge clk);
    repeat (3) tick("reset");
    rst = 0;
    tick("idle");
    start = 1; tick("start"); start = 0;
    run_instr(16'h2010, "lda");
    run_instr(16'h9020, "add_ind");
    dr_zero = 1; run_instr(16'h6030, "isz_zero");
    dr_zero = 0; run_instr(16'h6030, "isz_nz");
    run_instr(16'h7001, "hlt");
    repeat (20) tick("halted");
    start = 1; tick("restart"); start = 0;
    run_instr(16'h2010, "lda2");
    run_instr(16'hF080, "ion");
    fgi = 1; run_instr(16'h2010, "lda_irq");
    run_instr(16'h2010, "irq_cycle");
    fgi = 0; run_instr(16'h2010, "post_irq");
    tick("t0");
    force_t = 1; forced = 16'h0100; tick("recover_t8");
    forced = 16'h0000; tick("recover_t0");
    force_t = 0;
    for (int c = 0; c < 3000; c++) begin
      if (sc == 0) ir = rand_instr();
      ac_sign = 1'($urandom); ac_zero = 1'($urandom); e_flag = 1'($urandom);
      dr_zero = 1'($urandom); fgi = 1'($urandom); fgo = 1'($urandom);
      start = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 499) == 0);
      force_t = ($urandom_range(0, 49) == 0);
      forced = ($urandom_range(0, 3) == 0) ? 16'h0 : (16'h1 << $urandom_range(7, 15));
      tick("rand");
    end
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
